ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage of the single-cycle MIPS CPU: owns the program counter, drives the word address into the instruction memory and captures the returned 32-bit instruction into a one-entry output register with a valid/ready handshake toward decode. It applies branch/jump redirects, stalls on downstream backpressure and stops fetching after a SYSCALL. It sits directly upstream of the instruction memory and between that memory and the decode/control stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IM_DEPTH, 32, number of 32-bit words in instruction memory
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- im_addr  out  10  word address to instruction memory, always pc[11:2]
- im_dout  in  32  instruction word from memory, combinational from im_addr
- pc  out  32  current fetch PC
- instr  out  32  captured instruction
- instr_pc  out  32  PC of instr
- instr_valid  out  1  instr/instr_pc hold a live instruction
- instr_ready  in  1  decode accepts instr this cycle
- redirect_valid  in  1  branch/jump/jr taken
- redirect_pc  in  32  redirect target
- halted  out  1  SYSCALL fetched, fetching stopped
- fault  out  1  out-of-range fetch (see Configuration)

## Operation
- States: IDLE, FETCH, HALTED, FAULT (FAULT only reachable with macro).
- IDLE: entered on reset; exactly one cycle after rst deasserts, then FETCH. No capture, redirect ignored.
- FETCH, "slot free" = !instr_valid || instr_ready.
  - redirect_valid=1 (highest priority): pc <= {redirect_pc[31:2],2'b00}; instr_valid <= 0 (flushes held instruction even if not consumed); no capture.
  - else slot free: instr <= im_dout, instr_pc <= pc, instr_valid <= 1, pc <= pc+4 (modulo 2^32; 0xFFFFFFFC wraps to 0).
  - else (stall): pc, instr, instr_pc, instr_valid hold.
- SYSCALL: when a capture stores 32'h0000_000C, the capture completes normally, pc advances to syscall PC+4, state -> HALTED.
- HALTED: halted=1; no capture, pc frozen, redirect ignored; instr_valid clears on the cycle instr_ready=1; only rst exits.
- Output register cleared (instr_valid <= 0) on consumption when no new capture occurs.
- instr/instr_pc hold their last value when instr_valid=0.

## Timing
- im_addr combinational from pc register; instruction for PC p appears on instr one cycle after pc=p.
- Throughput one instruction per cycle with instr_ready held high.
- Redirect sampled at edge; first instruction from target valid two edges after redirect_valid asserted.
- Reset values: pc=RESET_PC, im_addr=RESET_PC[11:2], instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0, state IDLE.
- rst asserted mid-operation: all registers take reset values immediately (asynchronous), held until deassert; pending instruction discarded.
- Simultaneous redirect and instr_ready: held instruction counts as consumed, no new capture, instr_valid=0 next cycle.

## Configuration
- FETCH_BOUND_CHECK_EN defined: at a would-be capture in FETCH with pc[31:2] >= IM_DEPTH, no capture occurs, state -> FAULT, fault=1 (sticky until rst); FAULT behaves like HALTED (held instruction drains, no fetch, redirect ignored). Redirect in the same cycle takes priority and avoids the fault.
- Not defined: no range check; im_addr = pc[11:2] truncation, memory contents returned as-is; fault tied to 0; FAULT state absent.

## Test plan
- Reset release, instr_ready=1, IM words 0..3 = 0x20080001,0x20090002,0x01095020,0x0000000C -> instr_pc 0,4,8,C on consecutive cycles, halted=1 after capture at 0xC, pc=0x10, instr_valid drops next cycle.
- instr_ready=0 for 3 cycles with instr_valid=1 -> pc, instr, instr_pc stable; resume -> next PC captured with no skip or duplicate.
- redirect_valid with redirect_pc=0x0000_0013 while stalled -> instr_valid=0 next cycle, pc=0x10, then instr_pc=0x10.
- Macro defined, redirect to 0x80 (word 32, IM_DEPTH=32) -> fault=1, no capture, pc stays 0x80; macro undefined -> im_addr=0x20, capture proceeds, fault=0.
- rst pulse mid-stream (asynchronous, between edges) -> outputs immediately at reset values; fetch restarts from RESET_PC after one IDLE cycle.
- redirect_valid in HALTED and in IDLE -> ignored, pc unchanged.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, instruction memory addressing and a one-entry
// valid/ready output register. Optional FETCH_BOUND_CHECK_EN adds an out-of-range fetch fault.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] SYSCALL = 32'h0000_000C;

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [31:0] IM_WORDS = 32'(IM_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, HALTED, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
`endif

  state_t state;
  logic   slot_free;

  assign im_addr   = pc[11:2];
  assign slot_free = !instr_valid || instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          // Redirect wins over capture and flushes whatever is held.
          if (redirect_valid) begin
            pc          <= redirect_pc & 32'hFFFF_FFFC;
            instr_valid <= 1'b0;
          end else if (slot_free) begin
`ifdef FETCH_BOUND_CHECK_EN
            if ({2'b00, pc[31:2]} >= IM_WORDS) begin
              state       <= FAULT;
              fault       <= 1'b1;
              instr_valid <= 1'b0;
            end else
`endif
            begin
              instr       <= im_dout;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
              if (im_dout == SYSCALL) begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end
          end
        end
        // Terminal states only drain the held instruction.
        default: if (instr_ready) instr_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic,
// compared cycle by cycle against a behavioural fetch model.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IM_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc, instr, instr_pc;
  logic        instr_valid, halted, fault;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] mem [0:1023];
  assign im_dout = mem[im_addr];

  ifetch_unit #(.RESET_PC(RESET_PC), .IM_DEPTH(IM_DEPTH)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_dout(im_dout), .pc(pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: phase 0 = just out of reset, 1 = fetching, 2 = stopped by syscall, 3 = stopped by fault
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = RESET_PC; m_instr = 0; m_ipc = 0; m_valid = 0; m_fault = 0;
  endtask

  task automatic model_update();
    logic [31:0] w;
    if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      if (redirect_valid) begin
        m_pc = (redirect_pc / 4) * 4;
        m_valid = 0;
      end else if (!m_valid || instr_ready) begin
`ifdef FETCH_BOUND_CHECK_EN
        if (m_pc / 4 >= IM_DEPTH) begin
          m_phase = 3; m_fault = 1; m_valid = 0;
        end else
`endif
        begin
          w = mem[(m_pc / 4) % 1024];
          m_instr = w; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
          if (w == 32'h0000_000C) m_phase = 2;
        end
      end
    end else if (instr_ready) m_valid = 0;
  endtask

  task automatic cmp_all();
    chk("pc", pc, m_pc);
    chk("im_addr", {22'd0, im_addr}, {22'd0, m_pc[11:2]});
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, (m_phase == 2)});
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
  endtask

  task automatic step();
    model_update();
    @(posedge clk); #1;
    cmp_all();
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    cmp_all();
    @(posedge clk); #1;
    cmp_all();
    @(negedge clk); #2 rst = 1'b0;
  endtask

  task automatic fill_random(input int sys_odds);
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'h0000_000C) mem[i] = 32'h2000_0000;
      if (sys_odds > 0 && $urandom_range(sys_odds - 1, 0) == 0) mem[i] = 32'h0000_000C;
    end
  endtask

  initial begin
    logic [31:0] hold_pc, hold_instr, hold_ipc;
    fill_random(0);
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020; mem[3] = 32'h0000_000C;
    model_reset();
    #3 cmp_all();
    chk("reset_pc", pc, RESET_PC);
    @(negedge clk); #2 rst = 1'b0;

    // Straight-line program ending in SYSCALL; redirect in IDLE is ignored.
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    chk("idle_redirect_ignored", pc, RESET_PC);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_instr_pc", instr_pc, 32'(i * 4));
    end
    chk("syscall_halted", {31'd0, halted}, 32'd1);
    chk("syscall_pc", pc, 32'h0000_0010);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    step();
    chk("halt_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("halt_redirect_ignored", pc, 32'h0000_0010);
    redirect_valid = 1'b0;
    step();

    // Stall for three cycles, then resume without skip or duplicate.
    do_reset();
    fill_random(0);
    instr_ready = 1'b1;
    repeat (3) step();
    instr_ready = 1'b0;
    step();
    hold_pc = pc; hold_instr = instr; hold_ipc = instr_pc;
    repeat (3) begin
      step();
      chk("stall_pc", pc, hold_pc);
      chk("stall_instr", instr, hold_instr);
      chk("stall_ipc", instr_pc, hold_ipc);
    end
    instr_ready = 1'b1;
    step();
    chk("resume_ipc", instr_pc, hold_ipc + 4);

    // Redirect while stalled to an unaligned target.
    instr_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    step();
    chk("redir_flush", {31'd0, instr_valid}, 32'd0);
    chk("redir_pc", pc, 32'h0000_0010);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    step();
    chk("redir_target_ipc", instr_pc, 32'h0000_0010);

    // Redirect just past the memory bound.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    step();
    chk("bound_im_addr", {22'd0, im_addr}, 32'h0000_0020);
    redirect_valid = 1'b0;
    step();
`ifdef FETCH_BOUND_CHECK_EN
    chk("bound_fault", {31'd0, fault}, 32'd1);
    chk("bound_pc_held", pc, 32'h0000_0080);
`else
    chk("bound_capture", instr_pc, 32'h0000_0080);
    chk("bound_no_fault", {31'd0, fault}, 32'd0);
`endif
    step();

    // PC wrap at the top of the address space.
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    repeat (2) step();

    // Randomized traffic with occasional SYSCALLs and async resets.
    fill_random(40);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        instr_ready    = ($urandom_range(9, 0) < 7);
        redirect_valid = ($urandom_range(9, 0) == 0);
        redirect_pc    = ($urandom_range(7, 0) == 0) ? $urandom : 32'($urandom_range(255, 0));
        step();
      end
      redirect_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
